// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and the byte-lane merge helper.
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic logic [63:0] strb_merge(input logic [63:0] old_v, input logic [63:0] new_v, input logic [7:0] strb);
    for (int k = 0; k < 8; k++) strb_merge[k*8 +: 8] = strb[k] ? new_v[k*8 +: 8] : old_v[k*8 +: 8];
  endfunction
endpackage

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: register array with a byte-enable write port, a combinational read port and a flat export.
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 16,
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we_i,
  input  logic [IW-1:0]                  widx_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [STRB_WIDTH-1:0]          wstrb_i,
  input  logic [IW-1:0]                  ridx_i,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat_o
);
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    else if (we_i) mem_q[widx_i] <= DATA_WIDTH'(strb_merge(64'(mem_q[widx_i]), 64'(wdata_i), 8'(wstrb_i)));
  end
  assign rdata_o = mem_q[ridx_i];
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat_o[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
  end
endmodule

// File: rtl/axi_lite_slave_regfile.sv
// axi_lite_slave_regfile: AXI4-Lite responder over a byte-writable register bank.
// Independent AW/W latches merge into one commit; B and R are single-entry response registers.
module axi_lite_slave_regfile
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 16,
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]          wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  output logic                           wr_pulse,
  output logic [IW-1:0]                  wr_index
);
  localparam int LSB = $clog2(STRB_WIDTH);
  logic aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d, wr_pulse_q, wr_pulse_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, bank_rd;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [IW-1:0] wr_index_q, wr_index_d;
  logic aw_hs, w_hs, ar_hs, commit, w_ok, r_ok;
  always_comb begin
    aw_hs = awvalid && awready_q;
    w_hs = wvalid && wready_q;
    ar_hs = arvalid && arready_q;
    awaddr_d = aw_hs ? awaddr : awaddr_q;
    wdata_d = w_hs ? wdata : wdata_q;
    wstrb_d = w_hs ? wstrb : wstrb_q;
    commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    // Upper address bits take part in the range check so high addresses never alias onto the bank
    w_ok = (awaddr_d >> LSB) < ADDR_WIDTH'(NUM_REGS);
    r_ok = (araddr >> LSB) < ADDR_WIDTH'(NUM_REGS);
    aw_held_d = !commit && (aw_held_q || aw_hs);
    w_held_d = !commit && (w_held_q || w_hs);
    bvalid_d = commit || (bvalid_q && !bready);
    bresp_d = commit ? (w_ok ? RESP_OKAY : RESP_SLVERR) : bresp_q;
    wr_pulse_d = commit && w_ok;
    wr_index_d = wr_pulse_d ? awaddr_d[LSB +: IW] : wr_index_q;
    rvalid_d = ar_hs || (rvalid_q && !rready);
    rdata_d = ar_hs ? (r_ok ? bank_rd : '0) : rdata_q;
    rresp_d = ar_hs ? (r_ok ? RESP_OKAY : RESP_SLVERR) : rresp_q;
    awready_d = !aw_held_d && !bvalid_d;
    wready_d = !w_held_d && !bvalid_d;
    arready_d = !rvalid_d;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      {aw_held_q, w_held_q, awready_q, wready_q, arready_q, bvalid_q, rvalid_q, wr_pulse_q} <= '0;
      {bresp_q, rresp_q} <= '0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      wr_index_q <= '0;
    end else begin
      {aw_held_q, w_held_q, awready_q, wready_q, arready_q, bvalid_q, rvalid_q, wr_pulse_q} <=
        {aw_held_d, w_held_d, awready_d, wready_d, arready_d, bvalid_d, rvalid_d, wr_pulse_d};
      {bresp_q, rresp_q} <= {bresp_d, rresp_d};
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      wr_index_q <= wr_index_d;
    end
  end
  axi_lite_regbank #(
    .DATA_WIDTH(DATA_WIDTH),
    .STRB_WIDTH(STRB_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_bank (
    .clk        (aclk),
    .rst        (areset),
    .we_i       (wr_pulse_d),
    .widx_i     (awaddr_d[LSB +: IW]),
    .wdata_i    (wdata_d),
    .wstrb_i    (wstrb_d),
    .ridx_i     (araddr[LSB +: IW]),
    .rdata_o    (bank_rd),
    .regs_flat_o(regs_flat)
  );
  assign awready = awready_q;
  assign wready = wready_q;
  assign arready = arready_q;
  assign bvalid = bvalid_q;
  assign bresp = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_index = wr_index_q;
endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// tb_axi_lite_slave_regfile: directed and randomized checks against a register-array model.
module tb_axi_lite_slave_regfile;
  localparam int NR = 16;
  logic aclk = 0, areset = 1;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] wstrb = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, wr_pulse;
  logic [1:0] bresp, rresp;
  logic [3:0] wr_index;
  logic [NR*32-1:0] regs_flat;
  logic [31:0] model [NR];
  int errors = 0, checks = 0;

  always #5 aclk = ~aclk;

  axi_lite_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .NUM_REGS(NR)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_flat(regs_flat), .wr_pulse(wr_pulse), .wr_index(wr_index)
  );

  function automatic logic [1:0] mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a / 4 >= NR) return 2'b10;
    for (int k = 0; k < 4; k++) if (s[k]) model[a / 4][k*8 +: 8] = d[k*8 +: 8];
    return 2'b00;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    return (a / 4 < NR) ? model[a / 4] : 32'h0;
  endfunction

  function automatic logic [NR*32-1:0] exp_flat();
    for (int i = 0; i < NR; i++) exp_flat[i*32 +: 32] = model[i];
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int awd, input int wd,
                          output logic [1:0] resp, output int pulses, output int pidx, output int bc);
    bit aw_go, w_go, done;
    done = 0; pulses = 0; pidx = -1; bc = -1; resp = 2'bxx;
    bready = 1;
    @(negedge aclk);
    for (int c = 0; c < 100 && !done; c++) begin
      if (c == awd) begin awaddr = a; awvalid = 1; end
      if (c == wd) begin wdata = d; wstrb = s; wvalid = 1; end
      aw_go = awvalid && awready;
      w_go = wvalid && wready;
      if (wr_pulse) begin pulses++; pidx = int'(wr_index); end
      if (bvalid) begin resp = bresp; bc = c; done = 1; end
      @(negedge aclk);
      if (aw_go) awvalid = 0;
      if (w_go) wvalid = 0;
    end
    awvalid = 0; wvalid = 0;
    if (!done) begin errors++; checks++; $display("FAIL write_timeout addr=%h no bvalid within 100 cycles", a); end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    bit ar_go, r_go, done;
    done = 0; d = 'x; r = 'x;
    @(negedge aclk);
    araddr = a; arvalid = 1; rready = 1;
    for (int c = 0; c < 100 && !done; c++) begin
      ar_go = arvalid && arready;
      r_go = rvalid;
      if (rvalid) begin d = rdata; r = rresp; end
      @(negedge aclk);
      if (ar_go) arvalid = 0;
      if (r_go) done = 1;
    end
    arvalid = 0;
    if (!done) begin errors++; checks++; $display("FAIL read_timeout addr=%h no rvalid within 100 cycles", a); end
  endtask

  task automatic test_reset();
    areset = 1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, wr_pulse} !== 6'b0) begin
      errors++; $display("FAIL reset_hold handshake outputs=%b expected 000000", {awready, wready, arready, bvalid, rvalid, wr_pulse});
    end
    areset = 0;
    @(negedge aclk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL reset_ready aw/w/ar ready=%b expected 111", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, wr_pulse, bresp, rresp, wr_index} !== 11'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_outputs status=%b rdata=%h expected all zero", {bvalid, rvalid, wr_pulse, bresp, rresp, wr_index}, rdata);
    end
    checks++;
    if (regs_flat !== '0) begin errors++; $display("FAIL reset_regs regs_flat=%h expected 0", regs_flat); end
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
  endtask

  task automatic test_basic();
    logic [1:0] rs, rr; logic [31:0] d; int p, pi, bc;
    void'(mdl_write(32'h4, 32'hDEADBEEF, 4'hF));
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, rs, p, pi, bc);
    checks++;
    if (rs !== 2'b00 || bc != 1) begin errors++; $display("FAIL basic_bresp bresp=%b at cycle %0d expected 00 at cycle 1", rs, bc); end
    checks++;
    if (p != 1 || pi != 1) begin errors++; $display("FAIL basic_pulse pulses=%0d index=%0d expected 1 and 1", p, pi); end
    do_read(32'h4, d, rr);
    checks++;
    if (d !== 32'hDEADBEEF || rr !== 2'b00) begin errors++; $display("FAIL basic_read rdata=%h rresp=%b expected deadbeef 00", d, rr); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] rs; int p, pi, bc;
    void'(mdl_write(32'h8, 32'hAABBCCDD, 4'hF));
    do_write(32'h8, 32'hAABBCCDD, 4'hF, 0, 0, rs, p, pi, bc);
    void'(mdl_write(32'h0, 32'h12345678, 4'hF));
    do_write(32'h0, 32'h12345678, 4'hF, 0, 0, rs, p, pi, bc);
    void'(mdl_write(32'h8, 32'h11223344, 4'h5));
    do_write(32'h8, 32'h11223344, 4'h5, 2, 0, rs, p, pi, bc);
    checks++;
    if (rs !== 2'b00 || bc != 3 || p != 1 || pi != 2) begin
      errors++; $display("FAIL wfirst_resp bresp=%b cycle=%0d pulses=%0d idx=%0d expected 00 3 1 2", rs, bc, p, pi);
    end
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_single bvalid=%b after accept expected 0", bvalid); end
    checks++;
    if (regs_flat[2*32 +: 32] !== 32'hAA22CC44 || regs_flat !== exp_flat()) begin
      errors++; $display("FAIL wfirst_merge reg2=%h expected aa22cc44", regs_flat[2*32 +: 32]);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] rs, rr; logic [31:0] d; int p, pi, bc;
    do_write(32'h40, $urandom, 4'hF, 0, 0, rs, p, pi, bc);
    checks++;
    if (rs !== 2'b10 || p != 0) begin errors++; $display("FAIL oor_write bresp=%b pulses=%0d expected 10 and 0", rs, p); end
    checks++;
    if (regs_flat !== exp_flat()) begin errors++; $display("FAIL oor_regs regs_flat=%h expected %h", regs_flat, exp_flat()); end
    do_read(32'h1000_0000, d, rr);
    checks++;
    if (d !== 32'h0 || rr !== 2'b10) begin errors++; $display("FAIL oor_read rdata=%h rresp=%b expected 0 10", d, rr); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    @(negedge aclk);
    bready = 0; awaddr = 32'hC; wdata = d0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    void'(mdl_write(32'hC, d0, 4'hF));
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        errors++; $display("FAIL bp_b_hold cycle %0d bvalid=%b bresp=%b awready=%b wready=%b expected 1 00 0 0", i, bvalid, bresp, awready, wready);
      end
      if (i == 4) begin bready = 1; awaddr = 32'h10; wdata = d1; wstrb = 4'hF; awvalid = 1; wvalid = 1; end
      @(negedge aclk);
    end
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL bp_b_release bvalid=%b awready=%b wready=%b expected 0 1 1", bvalid, awready, wready);
    end
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    void'(mdl_write(32'h10, d1, 4'hF));
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || regs_flat !== exp_flat()) begin
      errors++; $display("FAIL bp_b_next bvalid=%b bresp=%b reg4=%h expected 1 00 %h", bvalid, bresp, regs_flat[4*32 +: 32], d1);
    end
    @(negedge aclk);
    rready = 0; araddr = 32'hC; arvalid = 1;
    @(negedge aclk);
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== model[3] || rresp !== 2'b00 || arready !== 1'b0) begin
        errors++; $display("FAIL bp_r_hold cycle %0d rvalid=%b rdata=%h rresp=%b arready=%b expected 1 %h 00 0", i, rvalid, rdata, rresp, arready, model[3]);
      end
      @(negedge aclk);
    end
    rready = 1;
    @(negedge aclk);
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL bp_r_release rvalid=%b arready=%b expected 0 1", rvalid, arready); end
  endtask

  task automatic test_collision();
    logic [1:0] rs, rr; logic [31:0] old_v, new_v, d; int p, pi, bc;
    old_v = $urandom; new_v = ~old_v;
    void'(mdl_write(32'hC, old_v, 4'hF));
    do_write(32'hC, old_v, 4'hF, 0, 0, rs, p, pi, bc);
    @(negedge aclk);
    awaddr = 32'hC; wdata = new_v; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'hC; arvalid = 1; bready = 1; rready = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== old_v) begin errors++; $display("FAIL collide_read rvalid=%b rdata=%h expected 1 %h", rvalid, rdata, old_v); end
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL collide_write bvalid=%b bresp=%b expected 1 00", bvalid, bresp); end
    void'(mdl_write(32'hC, new_v, 4'hF));
    do_read(32'hC, d, rr);
    checks++;
    if (d !== new_v) begin errors++; $display("FAIL collide_after rdata=%h expected %h", d, new_v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] dd;
    dd = $urandom;
    @(negedge aclk);
    awaddr = 32'h14; awvalid = 1; bready = 1;
    @(negedge aclk);
    awvalid = 0;
    checks++;
    if (awready !== 1'b0 || bvalid !== 1'b0) begin errors++; $display("FAIL midrst_held awready=%b bvalid=%b expected 0 0", awready, bvalid); end
    areset = 1;
    @(negedge aclk);
    areset = 0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    checks++;
    if (regs_flat !== '0 || bvalid !== 1'b0) begin errors++; $display("FAIL midrst_clear regs_flat=%h bvalid=%b expected 0 0", regs_flat, bvalid); end
    @(negedge aclk);
    wdata = dd; wstrb = 4'hF; wvalid = 1;
    @(negedge aclk);
    wvalid = 0;
    repeat (3) begin
      checks++;
      if (bvalid !== 1'b0) begin errors++; $display("FAIL midrst_no_b bvalid=%b with only W latched expected 0", bvalid); end
      @(negedge aclk);
    end
    awaddr = 32'h18; awvalid = 1;
    @(negedge aclk);
    awvalid = 0;
    void'(mdl_write(32'h18, dd, 4'hF));
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || wr_pulse !== 1'b1 || wr_index !== 4'd6) begin
      errors++; $display("FAIL midrst_next bvalid=%b bresp=%b pulse=%b idx=%0d expected 1 00 1 6", bvalid, bresp, wr_pulse, wr_index);
    end
    checks++;
    if (regs_flat !== exp_flat()) begin errors++; $display("FAIL midrst_regs regs_flat=%h expected %h", regs_flat, exp_flat()); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd; logic [3:0] s; logic [1:0] er, rs; int p, pi, bc, awd, wd;
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom_range(0, NR + 3) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom); awd = $urandom_range(0, 3); wd = $urandom_range(0, 3);
        er = mdl_write(a, d, s);
        do_write(a, d, s, awd, wd, rs, p, pi, bc);
        checks++;
        if (rs !== er || p != ((er == 2'b00) ? 1 : 0) || (er == 2'b00 && pi != int'(a / 4)) || bc != ((awd > wd) ? awd : wd) + 1) begin
          errors++; $display("FAIL rand_write addr=%h bresp=%b/%b pulses=%0d idx=%0d cycle=%0d (awd=%0d wd=%0d)", a, rs, er, p, pi, bc, awd, wd);
        end
      end else begin
        do_read(a, rd, rs);
        checks++;
        if (rd !== mdl_read(a) || rs !== ((a / 4 < NR) ? 2'b00 : 2'b10)) begin
          errors++; $display("FAIL rand_read addr=%h rdata=%h rresp=%b expected %h", a, rd, rs, mdl_read(a));
        end
      end
    end
    checks++;
    if (regs_flat !== exp_flat()) begin errors++; $display("FAIL rand_regs regs_flat=%h expected %h", regs_flat, exp_flat()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
